// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared helpers for the multi-channel CIC decimator:
//   clog2         - ceiling log2 for elaboration-time sizing
//   cic_out_w     - accumulator/output width that holds the full CIC gain
//   ch_w          - channel-index width (at least 1 bit)
//   cic_half_gain - (DEC*M)^ORDER / 2, the mid-scale offset for signed output
//   comb_state_t  - shared comb FSM states
// -----------------------------------------------------------------------------
package cic_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Bit growth of a CIC is ORDER*log2(R*M); one extra bit holds the peak
  // value (R*M)^ORDER itself, which an all-ones input reaches exactly.
  function automatic int cic_out_w(input int order, input int dec, input int diff_delay);
    return order * clog2(dec * diff_delay) + 1;
  endfunction

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? clog2(n_ch) : 1;
  endfunction

  function automatic longint cic_half_gain(input int order, input int dec, input int diff_delay);
    longint g;
    g = 1;
    for (int i = 0; i < order; i++) begin
      g = g * longint'(dec * diff_delay);
    end
    return g / 2;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } comb_state_t;

endpackage

// File: rtl/cic_integrator_chain.sv
// -----------------------------------------------------------------------------
// cic_integrator_chain
// One channel's ORDER cascaded integrators running at the PDM rate. The PDM
// bit enters as 0/+1. All stages advance together only when pdm_en is high;
// wrap-around is intended (CIC arithmetic is modular).
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   pdm_en    - sample qualifier
//   pdm       - this channel's PDM bit
//   acc_out   - final integrator value
// -----------------------------------------------------------------------------
module cic_integrator_chain #(
  parameter int ORDER = 3,
  parameter int W     = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pdm_en,
  input  logic         pdm,
  output logic [W-1:0] acc_out
);

  logic [W-1:0] acc     [ORDER];
  logic [W-1:0] acc_nxt [ORDER];

  // Each stage adds the already-updated value of the stage before it, so a
  // new PDM bit reaches the last stage in the same sample (no pipeline lag).
  always_comb begin
    logic [W-1:0] run;
    // NOTE: run is assigned before any read and every acc_nxt entry is written
    // on every pass, so no latch can be inferred here.
    run = {{(W-1){1'b0}}, pdm};
    for (int s = 0; s < ORDER; s++) begin
      run        = acc[s] + run;
      acc_nxt[s] = run;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < ORDER; s++) acc[s] <= '0;
    end else if (pdm_en) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples pre-edge values regardless of statement order.
      for (int s = 0; s < ORDER; s++) acc[s] <= acc_nxt[s];
    end
  end

  assign acc_out = acc[ORDER-1];

endmodule

// File: rtl/cic_multi_dec.sv
// -----------------------------------------------------------------------------
// cic_multi_dec
// Multi-channel CIC decimator: N_CH PDM streams -> channel-tagged PCM words.
// Per-channel integrators run on pdm_en; every DEC samples the final
// integrator values are snapshotted and a single time-shared comb chain
// processes one channel per cycle, emitting N_CH consecutive outputs.
//
// Optional build macro: CIC_SIGNED_OUT_EN
//   defined   - out_data = comb result - (DEC*M)^ORDER/2 (two's complement)
//   undefined - out_data = raw unsigned comb result
//
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   pdm_in       - one PDM bit per channel (bit k = channel k)
//   pdm_en       - qualifies pdm_in, one sample per asserted cycle
//   out_valid    - out_ch/out_data valid this cycle
//   out_ch       - channel index of out_data
//   out_data     - decimated sample, OUT_W bits
//   frame_start  - high with the channel-0 output of each frame
// -----------------------------------------------------------------------------
module cic_multi_dec
  import cic_pkg::*;
#(
  parameter  int N_CH       = 16,
  parameter  int ORDER      = 3,
  parameter  int DEC        = 64,
  parameter  int DIFF_DELAY = 1,
  localparam int OUT_W      = cic_out_w(ORDER, DEC, DIFF_DELAY),
  localparam int CH_W       = ch_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  pdm_in,
  input  logic             pdm_en,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [OUT_W-1:0] out_data,
  output logic             frame_start
);

  localparam int CNT_W = clog2(DEC);

  if (ORDER < 1 || ORDER > 5) begin : g_bad_order
    $error("cic_multi_dec: ORDER must be in 1..5");
  end
  if (DIFF_DELAY != 1 && DIFF_DELAY != 2) begin : g_bad_delay
    $error("cic_multi_dec: DIFF_DELAY must be 1 or 2");
  end
  if (DEC < 2 || (DEC & (DEC - 1)) != 0) begin : g_bad_dec_pow2
    $error("cic_multi_dec: DEC must be a power of two");
  end
  if (DEC < N_CH + 1) begin : g_bad_dec_overlap
    $error("cic_multi_dec: DEC must be at least N_CH+1");
  end

  // ---------------------------------------------------------------------------
  // Decimation counter. DEC is a power of two, so natural wrap gives 0..DEC-1.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] dec_cnt;
  logic             tick;
  logic             tick_d;

  assign tick = pdm_en && (dec_cnt == CNT_W'(DEC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_cnt <= '0;
      tick_d  <= 1'b0;
    end else begin
      tick_d <= tick;
      if (pdm_en) dec_cnt <= dec_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel integrators
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] int_out [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_int
    cic_integrator_chain #(
      .ORDER (ORDER),
      .W     (OUT_W)
    ) u_int (
      .clk     (clk),
      .rst     (rst),
      .pdm_en  (pdm_en),
      .pdm     (pdm_in[k]),
      .acc_out (int_out[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Snapshot: taken the cycle after the tick, so it holds exactly the samples
  // up to and including the tick sample even if a new sample arrives now.
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] snap [N_CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these register arrays are reset because the comb history must
      // start from zero for the start-up transient to be deterministic; they
      // are flops, not RAM, so clearing them is legal.
      for (int k = 0; k < N_CH; k++) snap[k] <= '0;
    end else if (tick_d) begin
      for (int k = 0; k < N_CH; k++) snap[k] <= int_out[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Shared comb datapath: channel ch_idx through ORDER stages y = x - x[n-M].
  // dly[ch][s][M-1] is the stage input from M frames ago.
  // ---------------------------------------------------------------------------
  comb_state_t      state;
  logic [CH_W-1:0]  ch_idx;
  logic [OUT_W-1:0] dly [N_CH][ORDER][DIFF_DELAY];
  logic [OUT_W-1:0] stage_in [ORDER];
  logic [OUT_W-1:0] comb_out;
  logic [OUT_W-1:0] result;

  always_comb begin
    logic [OUT_W-1:0] x;
    x = snap[ch_idx];
    for (int s = 0; s < ORDER; s++) begin
      stage_in[s] = x;
      x           = x - dly[ch_idx][s][DIFF_DELAY-1];
    end
    comb_out = x;
  end

`ifdef CIC_SIGNED_OUT_EN
  localparam logic [OUT_W-1:0] SIGN_OFFSET = OUT_W'(cic_half_gain(ORDER, DEC, DIFF_DELAY));
  assign result = comb_out - SIGN_OFFSET;
`else
  assign result = comb_out;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_CH; k++)
        for (int s = 0; s < ORDER; s++)
          for (int m = 0; m < DIFF_DELAY; m++)
            dly[k][s][m] <= '0;
    end else if (state == RUN) begin
      for (int s = 0; s < ORDER; s++) begin
        dly[ch_idx][s][0] <= stage_in[s];
        for (int m = 1; m < DIFF_DELAY; m++)
          dly[ch_idx][s][m] <= dly[ch_idx][s][m-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comb FSM and registered output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ch_idx      <= '0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_d) begin
            state  <= RUN;
            ch_idx <= '0;
          end
        end
        RUN: begin
          out_valid   <= 1'b1;
          out_ch      <= ch_idx;
          out_data    <= result;
          frame_start <= (ch_idx == '0);
          if (ch_idx == CH_W'(N_CH - 1)) begin
            state <= IDLE;
          end else begin
            ch_idx <= ch_idx + CH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_multi_dec.sv
// -----------------------------------------------------------------------------
// tb_cic_multi_dec
// Two decimators share stimulus: the default build (16 ch, order 3, R=64, M=1)
// and a small one (4 ch, order 2, R=16, M=2) fed from pdm_in[3:0].
// Expected values: steady gain (R*M)^ORDER for all-ones, half of it for a
// 1010... stream, 0 for zeros; first-frame all-ones values are the final
// integrator after R ones: C(66,3)=45760 and C(17,2)=136. Transients are
// ignored before frame 4 (full filter window reached in both builds).
// -----------------------------------------------------------------------------
module tb_cic_multi_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pdm_in = '0;
  logic        pdm_en = 1'b0;

  always #5 clk = ~clk;

  logic        v1, fs1;
  logic [3:0]  ch1;
  logic [18:0] d1;
  logic        v2, fs2;
  logic [1:0]  ch2;
  logic [10:0] d2;

  cic_multi_dec dut (
    .clk(clk), .rst(rst), .pdm_in(pdm_in), .pdm_en(pdm_en),
    .out_valid(v1), .out_ch(ch1), .out_data(d1), .frame_start(fs1)
  );

  cic_multi_dec #(.N_CH(4), .ORDER(2), .DEC(16), .DIFF_DELAY(2)) dut2 (
    .clk(clk), .rst(rst), .pdm_in(pdm_in[3:0]), .pdm_en(pdm_en),
    .out_valid(v2), .out_ch(ch2), .out_data(d2), .frame_start(fs2)
  );

`ifdef CIC_SIGNED_OUT_EN
  localparam int OFF1 = 131072;
  localparam int OFF2 = 512;
`else
  localparam int OFF1 = 0;
  localparam int OFF2 = 0;
`endif

  typedef struct {
    int          at_edge;
    int          ch;
    logic [31:0] data;
    logic        fs;
  } cap_t;

  typedef struct {
    string       name;
    logic [15:0] ones;     // channels held at 1
    logic [15:0] alt;      // channels driven 1010... per sample
    int          period;   // pdm_en every period-th cycle
    int          n_frames; // frames of the R=64 build
    int          one_a, alt_a, first_a;  // default build expectations
    int          one_b, alt_b, first_b;  // small build expectations
  } vec_t;

  cap_t cap1[$];
  cap_t cap2[$];
  int   samp_edge[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    cap_t c;
    if (v1) begin
      c.at_edge = edge_cnt; c.ch = int'(ch1); c.data = 32'(d1); c.fs = fs1;
      cap1.push_back(c);
    end
    if (v2) begin
      c.at_edge = edge_cnt; c.ch = int'(ch2); c.data = 32'(d2); c.fs = fs2;
      cap2.push_back(c);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [15:0] bits);
    @(posedge clk);
    #1;
    pdm_en = en;
    pdm_in = bits;
    if (en) samp_edge.push_back(edge_cnt + 1);
  endtask

  task automatic do_reset(input string tag);
    #1;
    rst    = 1'b0;
    pdm_en = 1'b0;
    pdm_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, " rst valid"}, 64'(v1), 64'(0));
    check({tag, " rst ch"},    64'(ch1), 64'(0));
    check({tag, " rst data"},  64'(d1), 64'(0));
    check({tag, " rst fs"},    64'(fs1), 64'(0));
    check({tag, " rst valid2"}, 64'(v2), 64'(0));
    check({tag, " rst data2"},  64'(d2), 64'(0));
    rst = 1'b1;
  endtask

  task automatic check_dut(input int which, input vec_t v);
    int   nch, dec, w, off, one, alt, first, nfr;
    cap_t q[$];
    if (which == 0) begin
      nch = 16; dec = 64; w = 19; off = OFF1;
      one = v.one_a; alt = v.alt_a; first = v.first_a; q = cap1;
    end else begin
      nch = 4; dec = 16; w = 11; off = OFF2;
      one = v.one_b; alt = v.alt_b; first = v.first_b; q = cap2;
    end
    nfr = v.n_frames * 64 / dec;
    check($sformatf("%s d%0d count", v.name, which), 64'(q.size()), 64'(nfr * nch));
    for (int i = 0; i < q.size() && i < nfr * nch; i++) begin
      int f, ch, raw;
      f  = i / nch + 1;
      ch = i % nch;
      check($sformatf("%s d%0d f%0d i%0d ch", v.name, which, f, i), 64'(q[i].ch), 64'(ch));
      check($sformatf("%s d%0d f%0d ch%0d fs", v.name, which, f, ch), 64'(q[i].fs), 64'(ch == 0));
      check($sformatf("%s d%0d f%0d ch%0d latency", v.name, which, f, ch),
            64'(q[i].at_edge), 64'(samp_edge[f*dec-1] + 2 + ch));
      if (f >= 4) begin
        raw = v.ones[ch] ? one : (v.alt[ch] ? alt : 0);
        check($sformatf("%s d%0d f%0d ch%0d data", v.name, which, f, ch),
              64'(q[i].data), 64'((raw - off) & ((1 << w) - 1)));
      end else if (f == 1 && v.ones[ch]) begin
        check($sformatf("%s d%0d f1 ch%0d first", v.name, which, ch),
              64'(q[i].data), 64'((first - off) & ((1 << w) - 1)));
      end
    end
  endtask

  task automatic stimulate_and_check(input vec_t v);
    int s, cyc;
    logic en;
    cap1.delete();
    cap2.delete();
    samp_edge.delete();
    s   = 0;
    cyc = 0;
    while (s < v.n_frames * 64) begin
      en = ((cyc % v.period) == 0);
      if (en) begin
        step(1'b1, v.ones | ((s % 2 == 0) ? v.alt : 16'h0000));
        s++;
      end else begin
        step(1'b0, 16'($urandom));  // ignored while pdm_en is low
      end
      cyc++;
    end
    repeat (24) step(1'b0, 16'h0000);
    check_dut(0, v);
    check_dut(1, v);
  endtask

  vec_t vecs[6];
  vec_t vr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    vecs[0] = '{"all_ones",  16'hFFFF, 16'h0000, 1, 5, 262144, 131072, 45760, 1024, 512, 136};
    vecs[1] = '{"ch3_alt",   16'h0000, 16'h0008, 1, 5, 262144, 131072, 45760, 1024, 512, 136};
    vecs[2] = '{"all_zero",  16'h0000, 16'h0000, 1, 5, 262144, 131072, 45760, 1024, 512, 136};
    vecs[3] = '{"ones_en3",  16'hFFFF, 16'h0000, 3, 5, 262144, 131072, 45760, 1024, 512, 136};
    vecs[4] = '{"mixed",     16'h00F5, 16'h0F0A, 1, 5, 262144, 131072, 45760, 1024, 512, 136};
    vecs[5] = '{"all_alt_en2", 16'h0000, 16'hFFFF, 2, 5, 262144, 131072, 45760, 1024, 512, 136};
    vr      = '{"after_rst", 16'hFFFF, 16'h0000, 1, 1, 262144, 131072, 45760, 1024, 512, 136};

    for (int i = 0; i < 6; i++) begin
      do_reset(vecs[i].name);
      stimulate_and_check(vecs[i]);
    end

    // Reset pulsed while channel 7 is on the output: everything clears at
    // once, and the next frame arrives 64 samples after release with the
    // start-up transient repeated.
    do_reset("mid_frame");
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 16'hFFFF);
      if (v1 && ch1 == 4'd7) found = 1'b1;
    end
    check("mid_frame ch7 seen", 64'(found), 64'(1));
    rst = 1'b0;
    #1;
    check("mid_frame valid", 64'(v1), 64'(0));
    check("mid_frame ch",    64'(ch1), 64'(0));
    check("mid_frame data",  64'(d1), 64'(0));
    check("mid_frame fs",    64'(fs1), 64'(0));
    check("mid_frame valid2", 64'(v2), 64'(0));
    pdm_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    stimulate_and_check(vr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
